fwd_hazard_unit: RTL and testbench

//  Successor forwarding/hazard block for the 5-stage RV pipeline with a pipelined multiplier.

---
 rtl/fwd_hazard_unit_if.sv | 47 ++++
 rtl/fwd_hazard_unit.sv | 147 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_if.sv
// Bundle between the pipeline control and the forwarding/hazard unit.
// The pipeline (master) drives the register tags and control flags.
// The hazard unit (slave) returns forward selects, stall, multiplier
// writeback tag and the stall counter.
interface fwd_hazard_unit_if #(
    parameter int REG_AW      = 5,
    parameter int STALL_CNT_W = 16
);
    // ID stage
    logic [REG_AW-1:0]      id_rs1;
    logic [REG_AW-1:0]      id_rs2;
    logic [REG_AW-1:0]      id_rd;
    logic                   id_reg_write;
    // ID/EX register
    logic [REG_AW-1:0]      id_ex_rs1;
    logic [REG_AW-1:0]      id_ex_rs2;
    logic [REG_AW-1:0]      id_ex_rd;
    logic                   id_ex_mem_read;
    logic                   id_ex_alu_src;
    logic                   ex_mul_issue;
    // later pipeline registers
    logic                   ex_mem_reg_write;
    logic [REG_AW-1:0]      ex_mem_rd;
    logic                   mem_wb_reg_write;
    logic [REG_AW-1:0]      mem_wb_rd;
    // results
    logic [1:0]             forward_a;
    logic [1:0]             forward_b;
    logic                   stall;
    logic                   mul_wb_valid;
    logic [REG_AW-1:0]      mul_wb_rd;
    logic [STALL_CNT_W-1:0] stall_cnt;

    modport master (
        output id_rs1, id_rs2, id_rd, id_reg_write,
        output id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_alu_src, ex_mul_issue,
        output ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd,
        input  forward_a, forward_b, stall, mul_wb_valid, mul_wb_rd, stall_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rd, id_reg_write,
        input  id_ex_rs1, id_ex_rs2, id_ex_rd, id_ex_mem_read, id_ex_alu_src, ex_mul_issue,
        input  ex_mem_reg_write, ex_mem_rd, mem_wb_reg_write, mem_wb_rd,
        output forward_a, forward_b, stall, mul_wb_valid, mul_wb_rd, stall_cnt
    );
endinterface

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard unit for the 5-stage pipeline with a pipelined
// multiplier. Produces ALU operand forward selects and the ID-stage stall
// (load-use, mul-use, mul WAW). Pending multiply destinations travel down a
// MUL_LAT-deep shift scoreboard that advances every cycle regardless of stall.
// Optional feature macro: MUL_FWD_EN (forward the multiplier result straight
// into EX with select 11, shortening the mul-use stall window).
// MUL_LAT must be at least 2.
module fwd_hazard_unit #(
    parameter int REG_AW      = 5,
    parameter int MUL_LAT     = 3,
    parameter int STALL_CNT_W = 16
) (
    input  logic             clk,
    input  logic             arst_n,
    fwd_hazard_unit_if.slave bus
);

    // Last scoreboard stage that still blocks a consumer in ID. The final
    // stage writes back this cycle and the register file is write-through,
    // so it never needs to stall a reader. With result forwarding the
    // stage before it is also covered: the consumer reaches EX exactly when
    // the producer reaches the final stage and takes select 11.
`ifdef MUL_FWD_EN
    localparam int USE_LAST = MUL_LAT - 3;
`else
    localparam int USE_LAST = MUL_LAT - 2;
`endif

    // valid && non-zero && equal; x0 never matches
    function automatic logic hit(input logic v,
                                 input logic [REG_AW-1:0] x,
                                 input logic [REG_AW-1:0] r);
        return v && (x != '0) && (x == r);
    endfunction

    logic [MUL_LAT-1:0]     sb_valid_q;
    logic [REG_AW-1:0]      sb_rd_q [MUL_LAT];
    logic [STALL_CNT_W-1:0] stall_cnt_q;
    logic [STALL_CNT_W-1:0] stall_cnt_d;

    logic                   issue_valid;
    logic [MUL_LAT-1:0]     use_hit;
    logic [MUL_LAT-1:0]     waw_hit;
    logic                   issue_use;
    logic                   issue_waw;
    logic                   load_use;
    logic                   mul_use;
    logic                   mul_waw;
    logic                   stall;
    logic                   mul_fwd_a;
    logic                   mul_fwd_b;
    logic [1:0]             fwd_a;
    logic [1:0]             fwd_b;

    assign issue_valid = bus.ex_mul_issue && (bus.id_ex_rd != '0);

    // Free-running scoreboard shift; a reset discards every in-flight tag
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            sb_valid_q <= '0;
            for (int k = 0; k < MUL_LAT; k++) begin
                sb_rd_q[k] <= '0;
            end
        end else begin
            sb_valid_q <= {sb_valid_q[MUL_LAT-2:0], issue_valid};
            sb_rd_q[0] <= bus.id_ex_rd;
            for (int k = 1; k < MUL_LAT; k++) begin
                sb_rd_q[k] <= sb_rd_q[k-1];
            end
        end
    end

    // Per-stage comparisons against the instruction sitting in ID
    genvar gi;
    for (gi = 0; gi < MUL_LAT; gi++) begin : g_stage
        assign use_hit[gi] = (gi <= USE_LAST) &&
                             (hit(sb_valid_q[gi], bus.id_rs1, sb_rd_q[gi]) ||
                              hit(sb_valid_q[gi], bus.id_rs2, sb_rd_q[gi]));
        // WAW covers every stage, including the one writing back now
        assign waw_hit[gi] = hit(sb_valid_q[gi], bus.id_rd, sb_rd_q[gi]);
    end

    // A mul entering the multiplier this cycle is not yet in the
    // scoreboard, so it is checked directly from the ID/EX tag.
    assign issue_use = bus.ex_mul_issue &&
                       (hit(1'b1, bus.id_rs1, bus.id_ex_rd) ||
                        hit(1'b1, bus.id_rs2, bus.id_ex_rd));
    assign issue_waw = bus.ex_mul_issue && hit(1'b1, bus.id_rd, bus.id_ex_rd);

    assign load_use = bus.id_ex_mem_read &&
                      (hit(1'b1, bus.id_rs1, bus.id_ex_rd) ||
                       hit(1'b1, bus.id_rs2, bus.id_ex_rd));
    assign mul_use  = (|use_hit) || issue_use;
    assign mul_waw  = bus.id_reg_write && ((|waw_hit) || issue_waw);
    assign stall    = load_use || mul_use || mul_waw;

`ifdef MUL_FWD_EN
    assign mul_fwd_a = hit(sb_valid_q[MUL_LAT-1], bus.id_ex_rs1, sb_rd_q[MUL_LAT-1]);
    assign mul_fwd_b = hit(sb_valid_q[MUL_LAT-1], bus.id_ex_rs2, sb_rd_q[MUL_LAT-1]);
`else
    assign mul_fwd_a = 1'b0;
    assign mul_fwd_b = 1'b0;
`endif

    // Operand forward selects: multiplier, then EX/MEM, then MEM/WB
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (mul_fwd_a) begin
            fwd_a = 2'b11;
        end else if (hit(bus.ex_mem_reg_write, bus.id_ex_rs1, bus.ex_mem_rd)) begin
            fwd_a = 2'b10;
        end else if (hit(bus.mem_wb_reg_write, bus.id_ex_rs1, bus.mem_wb_rd)) begin
            fwd_a = 2'b01;
        end
        // Immediate operand B never takes a forwarded value
        if (!bus.id_ex_alu_src) begin
            if (mul_fwd_b) begin
                fwd_b = 2'b11;
            end else if (hit(bus.ex_mem_reg_write, bus.id_ex_rs2, bus.ex_mem_rd)) begin
                fwd_b = 2'b10;
            end else if (hit(bus.mem_wb_reg_write, bus.id_ex_rs2, bus.mem_wb_rd)) begin
                fwd_b = 2'b01;
            end
        end
    end

    assign stall_cnt_d = (stall && !(&stall_cnt_q)) ? stall_cnt_q + STALL_CNT_W'(1)
                                                    : stall_cnt_q;

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign bus.forward_a    = fwd_a;
    assign bus.forward_b    = fwd_b;
    assign bus.stall        = stall;
    assign bus.mul_wb_valid = sb_valid_q[MUL_LAT-1];
    assign bus.mul_wb_rd    = sb_rd_q[MUL_LAT-1];
    assign bus.stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit (MUL_LAT=3, STALL_CNT_W=4).
// Directed scenarios use hand-derived constants; the random scenario uses a
// reference model that logs each multiply by its issue cycle and derives
// hazards from the multiply's age.
module tb_fwd_hazard_unit;

    localparam int MUL_LAT = 3;
    localparam int CNT_MAX = 15;
`ifdef MUL_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif
    // Stalls seen by a consumer issued right behind its mul
    localparam int EXP_USE_STALLS = FWD_EN ? MUL_LAT - 1 : MUL_LAT;
    // Last age (cycles since issue) at which a reader in ID must wait
    localparam int USE_LAST_AGE   = FWD_EN ? MUL_LAT - 2 : MUL_LAT - 1;

    logic clk = 1'b0;
    logic arst_n = 1'b0;
    always #5 clk = ~clk;

    fwd_hazard_unit_if #(.REG_AW(5), .STALL_CNT_W(4)) bus ();

    fwd_hazard_unit #(.REG_AW(5), .MUL_LAT(MUL_LAT), .STALL_CNT_W(4)) u_dut (
        .clk    (clk),
        .arst_n (arst_n),
        .bus    (bus)
    );

    int cmp_cnt = 0;
    int err_cnt = 0;

    // reference model state
    typedef struct { logic [4:0] rd; int ic; } mul_t;
    mul_t log_q[$];
    int   cyc   = 0;
    int   cnt_m = 0;

    function automatic logic exp_stall();
        logic s = 1'b0;
        logic [4:0] r1 = bus.id_rs1;
        logic [4:0] r2 = bus.id_rs2;
        logic [4:0] er = bus.id_ex_rd;
        if (bus.id_ex_mem_read && er != 0 && (er == r1 || er == r2)) s = 1'b1;
        if (bus.ex_mul_issue && er != 0) begin
            if (er == r1 || er == r2) s = 1'b1;
            if (bus.id_reg_write && bus.id_rd == er) s = 1'b1;
        end
        foreach (log_q[i]) begin
            int d = cyc - log_q[i].ic;
            if (d >= 1 && d <= USE_LAST_AGE && (log_q[i].rd == r1 || log_q[i].rd == r2)) s = 1'b1;
            if (bus.id_reg_write && log_q[i].rd == bus.id_rd && d >= 1 && d <= MUL_LAT) s = 1'b1;
        end
        return s;
    endfunction

    function automatic logic [1:0] exp_fwd(input logic [4:0] src);
        if (src == 0) return 2'b00;
        if (FWD_EN) begin
            foreach (log_q[i]) begin
                if (cyc - log_q[i].ic == MUL_LAT && log_q[i].rd == src) return 2'b11;
            end
        end
        if (bus.ex_mem_reg_write && bus.ex_mem_rd == src) return 2'b10;
        if (bus.mem_wb_reg_write && bus.mem_wb_rd == src) return 2'b01;
        return 2'b00;
    endfunction

    function automatic int exp_wb_idx();
        foreach (log_q[i]) begin
            if (cyc - log_q[i].ic == MUL_LAT) return i;
        end
        return -1;
    endfunction

    task automatic idle();
        bus.id_rs1 = 0; bus.id_rs2 = 0; bus.id_rd = 0; bus.id_reg_write = 0;
        bus.id_ex_rs1 = 0; bus.id_ex_rs2 = 0; bus.id_ex_rd = 0;
        bus.id_ex_mem_read = 0; bus.id_ex_alu_src = 0; bus.ex_mul_issue = 0;
        bus.ex_mem_reg_write = 0; bus.ex_mem_rd = 0;
        bus.mem_wb_reg_write = 0; bus.mem_wb_rd = 0;
    endtask

    // Advance one clock and keep the model in step with the current inputs
    task automatic tick();
        logic s;
        s = exp_stall();
        @(posedge clk);
        if (bus.ex_mul_issue && bus.id_ex_rd != 0) log_q.push_back('{rd: bus.id_ex_rd, ic: cyc});
        if (s && cnt_m < CNT_MAX) cnt_m++;
        cyc++;
        while (log_q.size() > 0 && cyc - log_q[0].ic > MUL_LAT) void'(log_q.pop_front());
        #1;
    endtask

    task automatic do_reset();
        idle();
        @(negedge clk);
        arst_n = 1'b0;
        @(negedge clk);
        arst_n = 1'b1;
        log_q.delete();
        cnt_m = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        // fill the scoreboard with x1, x2, x3
        for (int i = 1; i <= 3; i++) begin
            bus.ex_mul_issue = 1'b1;
            bus.id_ex_rd = 5'(i);
            tick();
        end
        idle();
        bus.id_rs1 = 5'd3;
        @(negedge clk);
        cmp_cnt++;
        if (bus.mul_wb_valid !== 1'b1 || bus.mul_wb_rd !== 5'd1) begin
            err_cnt++;
            $display("FAIL reset_prefill_wb: got valid=%0b rd=%0d required valid=1 rd=1", bus.mul_wb_valid, bus.mul_wb_rd);
        end
        cmp_cnt++;
        if (bus.stall !== 1'b1) begin
            err_cnt++;
            $display("FAIL reset_prefill_stall: got %0b required 1", bus.stall);
        end
        #2;
        arst_n = 1'b0;
        #1;
        cmp_cnt++;
        if (bus.stall !== 1'b0 || bus.mul_wb_valid !== 1'b0 || bus.mul_wb_rd !== 5'd0 || bus.stall_cnt !== 4'd0) begin
            err_cnt++;
            $display("FAIL reset_async: got stall=%0b wbv=%0b wbrd=%0d cnt=%0d required 0/0/0/0",
                     bus.stall, bus.mul_wb_valid, bus.mul_wb_rd, bus.stall_cnt);
        end
        @(negedge clk);
        arst_n = 1'b1;
        log_q.delete();
        cnt_m = 0;
        @(posedge clk);
        #1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.stall !== 1'b0 || bus.mul_wb_valid !== 1'b0 || bus.stall_cnt !== 4'd0 ||
            bus.forward_a !== 2'b00 || bus.forward_b !== 2'b00) begin
            err_cnt++;
            $display("FAIL reset_release: got stall=%0b wbv=%0b cnt=%0d fa=%0d fb=%0d required all 0",
                     bus.stall, bus.mul_wb_valid, bus.stall_cnt, bus.forward_a, bus.forward_b);
        end
        $display("test_reset done");
    endtask

    task automatic test_alu_chain();
        do_reset();
        bus.ex_mem_reg_write = 1; bus.ex_mem_rd = 5;
        bus.mem_wb_reg_write = 1; bus.mem_wb_rd = 5;
        bus.id_ex_rs1 = 5;
        @(negedge clk);
        cmp_cnt++;
        if (bus.forward_a !== 2'b10) begin
            err_cnt++;
            $display("FAIL alu_exmem_priority: got %0d required 2", bus.forward_a);
        end
        tick();
        bus.ex_mem_reg_write = 0;
        @(negedge clk);
        cmp_cnt++;
        if (bus.forward_a !== 2'b01) begin
            err_cnt++;
            $display("FAIL alu_memwb: got %0d required 1", bus.forward_a);
        end
        tick();
        bus.ex_mem_reg_write = 1; bus.ex_mem_rd = 0; bus.mem_wb_rd = 0; bus.id_ex_rs1 = 0;
        @(negedge clk);
        cmp_cnt++;
        if (bus.forward_a !== 2'b00) begin
            err_cnt++;
            $display("FAIL alu_x0: got %0d required 0", bus.forward_a);
        end
        tick();
        bus.ex_mem_rd = 5; bus.mem_wb_rd = 5; bus.id_ex_rs2 = 5; bus.id_ex_alu_src = 1;
        @(negedge clk);
        cmp_cnt++;
        if (bus.forward_b !== 2'b00) begin
            err_cnt++;
            $display("FAIL alu_imm_b: got %0d required 0", bus.forward_b);
        end
        tick();
        bus.id_ex_alu_src = 0;
        @(negedge clk);
        cmp_cnt++;
        if (bus.forward_b !== 2'b10) begin
            err_cnt++;
            $display("FAIL alu_reg_b: got %0d required 2", bus.forward_b);
        end
        $display("test_alu_chain done");
    endtask

    task automatic test_load_use();
        do_reset();
        bus.id_ex_mem_read = 1; bus.id_ex_rd = 7; bus.id_rs2 = 7;
        @(negedge clk);
        cmp_cnt++;
        if (bus.stall !== 1'b1) begin
            err_cnt++;
            $display("FAIL load_use_stall: got %0b required 1", bus.stall);
        end
        tick();
        // bubble now in EX, the load moved on
        bus.id_ex_mem_read = 0; bus.id_ex_rd = 0;
        @(negedge clk);
        cmp_cnt++;
        if (bus.stall !== 1'b0 || bus.stall_cnt !== 4'd1) begin
            err_cnt++;
            $display("FAIL load_use_release: got stall=%0b cnt=%0d required stall=0 cnt=1", bus.stall, bus.stall_cnt);
        end
        $display("test_load_use done");
    endtask

    task automatic test_mul_use();
        int  n = 0;
        bit  done = 0;
        logic wbv_rel;
        do_reset();
        bus.ex_mul_issue = 1; bus.id_ex_rd = 9; bus.id_rs1 = 9;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (bus.stall) n++; else done = 1;
            if (!done) begin
                tick();
                bus.ex_mul_issue = 0; bus.id_ex_rd = 0;
            end
        end
        cmp_cnt++;
        if (!done) begin
            err_cnt++;
            $display("FAIL mul_use_timeout: stall still 1 after 10 cycles, required release");
        end
        cmp_cnt++;
        if (n != EXP_USE_STALLS) begin
            err_cnt++;
            $display("FAIL mul_use_stall_len: got %0d required %0d", n, EXP_USE_STALLS);
        end
        wbv_rel = FWD_EN ? 1'b0 : 1'b1;
        cmp_cnt++;
        if (bus.mul_wb_valid !== wbv_rel) begin
            err_cnt++;
            $display("FAIL mul_use_release_wb: got %0b required %0b", bus.mul_wb_valid, wbv_rel);
        end
        tick();
        bus.id_rs1 = 0; bus.id_ex_rs1 = 9;
        @(negedge clk);
        cmp_cnt++;
        if (bus.forward_a !== (FWD_EN ? 2'b11 : 2'b00)) begin
            err_cnt++;
            $display("FAIL mul_use_fwd: got %0d required %0d", bus.forward_a, FWD_EN ? 3 : 0);
        end
        cmp_cnt++;
        if (bus.stall_cnt !== 4'(EXP_USE_STALLS)) begin
            err_cnt++;
            $display("FAIL mul_use_cnt: got %0d required %0d", bus.stall_cnt, EXP_USE_STALLS);
        end
        $display("test_mul_use done: %0d stall cycles", n);
    endtask

    task automatic test_waw();
        int n = 0;
        bit done = 0;
        bit seen_wb = 0;
        do_reset();
        bus.ex_mul_issue = 1; bus.id_ex_rd = 4; bus.id_reg_write = 1; bus.id_rd = 4;
        for (int c = 0; c < 10 && !done; c++) begin
            @(negedge clk);
            if (bus.stall) begin
                n++;
                if (bus.mul_wb_valid && bus.mul_wb_rd == 5'd4) seen_wb = 1;
            end else begin
                done = 1;
            end
            if (!done) begin
                tick();
                bus.ex_mul_issue = 0; bus.id_ex_rd = 0;
            end
        end
        cmp_cnt++;
        if (!done) begin
            err_cnt++;
            $display("FAIL waw_timeout: stall still 1 after 10 cycles, required release");
        end
        cmp_cnt++;
        if (n != MUL_LAT + 1 || !seen_wb) begin
            err_cnt++;
            $display("FAIL waw_stall_len: got %0d cycles wb_seen=%0b required %0d cycles wb_seen=1", n, seen_wb, MUL_LAT + 1);
        end
        cmp_cnt++;
        if (bus.mul_wb_valid !== 1'b0) begin
            err_cnt++;
            $display("FAIL waw_retired: got wb_valid=%0b required 0", bus.mul_wb_valid);
        end
        $display("test_waw done: %0d stall cycles", n);
    endtask

    task automatic test_saturation();
        do_reset();
        bus.id_ex_mem_read = 1; bus.id_ex_rd = 7; bus.id_rs1 = 7;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (i == 9) begin
                cmp_cnt++;
                if (bus.stall_cnt !== 4'd10) begin
                    err_cnt++;
                    $display("FAIL sat_mid: got %0d required 10", bus.stall_cnt);
                end
            end
        end
        @(negedge clk);
        cmp_cnt++;
        if (bus.stall_cnt !== 4'd15 || bus.stall !== 1'b1) begin
            err_cnt++;
            $display("FAIL sat_hold: got cnt=%0d stall=%0b required cnt=15 stall=1", bus.stall_cnt, bus.stall);
        end
        $display("test_saturation done");
    endtask

    task automatic test_random();
        logic [1:0] efa, efb;
        logic       es;
        int         wi;
        do_reset();
        for (int t = 0; t < 400; t++) begin
            bus.id_rs1           = 5'($urandom_range(0, 3));
            bus.id_rs2           = 5'($urandom_range(0, 3));
            bus.id_rd            = 5'($urandom_range(0, 3));
            bus.id_reg_write     = ($urandom_range(0, 3) == 0);
            bus.id_ex_rs1        = 5'($urandom_range(0, 3));
            bus.id_ex_rs2        = 5'($urandom_range(0, 3));
            bus.id_ex_rd         = 5'($urandom_range(0, 3));
            bus.id_ex_mem_read   = ($urandom_range(0, 4) == 0);
            bus.id_ex_alu_src    = ($urandom_range(0, 2) == 0);
            bus.ex_mul_issue     = ($urandom_range(0, 2) == 0);
            bus.ex_mem_reg_write = $urandom_range(0, 1) == 1;
            bus.ex_mem_rd        = 5'($urandom_range(0, 3));
            bus.mem_wb_reg_write = $urandom_range(0, 1) == 1;
            bus.mem_wb_rd        = 5'($urandom_range(0, 3));
            @(negedge clk);
            efa = exp_fwd(bus.id_ex_rs1);
            efb = bus.id_ex_alu_src ? 2'b00 : exp_fwd(bus.id_ex_rs2);
            es  = exp_stall();
            wi  = exp_wb_idx();
            cmp_cnt++;
            if (bus.forward_a !== efa || bus.forward_b !== efb) begin
                err_cnt++;
                $display("FAIL rnd_fwd t=%0d: got fa=%0d fb=%0d required fa=%0d fb=%0d", t, bus.forward_a, bus.forward_b, efa, efb);
            end
            cmp_cnt++;
            if (bus.stall !== es) begin
                err_cnt++;
                $display("FAIL rnd_stall t=%0d: got %0b required %0b", t, bus.stall, es);
            end
            cmp_cnt++;
            if (bus.mul_wb_valid !== (wi >= 0) || (wi >= 0 && bus.mul_wb_rd !== log_q[wi].rd)) begin
                err_cnt++;
                $display("FAIL rnd_wb t=%0d: got valid=%0b rd=%0d required valid=%0b", t, bus.mul_wb_valid, bus.mul_wb_rd, wi >= 0);
            end
            cmp_cnt++;
            if (bus.stall_cnt !== 4'(cnt_m)) begin
                err_cnt++;
                $display("FAIL rnd_cnt t=%0d: got %0d required %0d", t, bus.stall_cnt, cnt_m);
            end
            tick();
        end
        $display("test_random done: 400 cycles");
    endtask

    initial begin
        idle();
        test_reset();
        test_alu_chain();
        test_load_use();
        test_mul_use();
        test_waw();
        test_saturation();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule
